// File: rtl/baccarat_pkg.sv
// baccarat_pkg: card codes, natural bounds and hand FSM states
// shared by the baccarat hand datapath.
package baccarat_pkg;

    typedef logic [3:0] card_t;

    localparam card_t CARD_ACE  = 4'd1;
    localparam card_t CARD_TEN  = 4'd10;
    localparam card_t CARD_KING = 4'd13;

    localparam int NATURAL_LO = 8;
    localparam int NATURAL_HI = 9;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } hand_state_e;

    // Legal codes are ace through king.
    function automatic logic card_is_legal(input card_t c);
        return (c >= CARD_ACE) && (c <= CARD_KING);
    endfunction

endpackage

// File: rtl/hand_accumulator_card_to_value.sv
// card_to_value: maps a dealt card code to its baccarat point value.
// Tens and faces score zero; out-of-range codes score zero and flag illegal.
module card_to_value
    import baccarat_pkg::*;
(
    input  card_t      card,
    output logic [3:0] value,
    output logic       illegal
);

    // Decode the code into a value in 0..9 and a legality flag.
    always_comb begin
        value   = '0;
        illegal = 1'b0;
        unique case (1'b1)
            (card >= CARD_ACE) && (card < CARD_TEN): begin
                value = card;
            end
            (card >= CARD_TEN) && (card <= CARD_KING): begin
                value = '0;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/hand_accumulator.sv
// hand_accumulator: running baccarat hand score over a valid/ready card port.
// Define HAND_HISTORY_EN to add a readable per-hand card history (rd_idx/rd_card).
module hand_accumulator
    import baccarat_pkg::*;
#(
    parameter int MAX_CARDS = 3,
    parameter int MODULUS   = 10,
    parameter int SCORE_W   = $clog2(MODULUS),
    parameter int CNT_W     = $clog2(MAX_CARDS + 1)
) (
    input  logic               slow_clock,
    input  logic               resetb,
    input  logic               clear,
    input  logic               card_valid,
    input  logic [3:0]         card,
    output logic               card_ready,
    output logic [SCORE_W-1:0] score,
    output logic [CNT_W-1:0]   num_cards,
    output logic               full,
    output logic               natural,
`ifdef HAND_HISTORY_EN
    input  logic [CNT_W-1:0]   rd_idx,
    output logic [3:0]         rd_card,
`endif
    output logic               illegal
);

    localparam int SUM_W = SCORE_W + 1;

    hand_state_e        state;
    hand_state_e        state_nxt;
    logic [3:0]         value;
    logic               code_bad;
    logic               accept;
    logic [SUM_W-1:0]   sum;
    logic [SCORE_W-1:0] score_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               last_card;
    logic               nat_nxt;

    card_to_value u_value (
        .card    (card),
        .value   (value),
        .illegal (code_bad)
    );

    assign full       = (state == ST_DONE);
    assign card_ready = !full && !clear;
    assign accept     = card_valid && card_ready;

    // Value is at most 9 and below the modulus, so one subtract wraps the sum.
    assign sum       = {1'b0, score} + SUM_W'(value);
    assign score_nxt = (sum >= SUM_W'(MODULUS))
                     ? SCORE_W'(sum - SUM_W'(MODULUS))
                     : SCORE_W'(sum);
    assign cnt_nxt   = num_cards + CNT_W'(1);
    assign last_card = (cnt_nxt == CNT_W'(MAX_CARDS));

    // A natural is judged on the hand as it will stand after this card.
    assign nat_nxt = (cnt_nxt == CNT_W'(2))
                  && ((score_nxt == SCORE_W'(NATURAL_LO))
                   || (score_nxt == SCORE_W'(NATURAL_HI)));

    // Next hand state: fill up on accepts, clear always returns to empty.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nxt = last_card ? ST_DONE : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (accept && last_card) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_DONE;
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase
        if (clear) begin
            state_nxt = ST_EMPTY;
        end
    end

    // Hand state register.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Score, count and flags move only on an accepted card or a clear.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            score     <= '0;
            num_cards <= '0;
            natural   <= 1'b0;
            illegal   <= 1'b0;
        end else if (clear) begin
            score     <= '0;
            num_cards <= '0;
            natural   <= 1'b0;
            illegal   <= 1'b0;
        end else if (accept) begin
            score     <= score_nxt;
            num_cards <= cnt_nxt;
            natural   <= nat_nxt;
            illegal   <= illegal | code_bad;
        end
    end

`ifdef HAND_HISTORY_EN
    card_t hist [MAX_CARDS];

    // Each accepted card lands in the slot given by the pre-increment count.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < MAX_CARDS; i++) begin
                hist[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < MAX_CARDS; i++) begin
                hist[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < MAX_CARDS; i++) begin
                if (num_cards == CNT_W'(i)) begin
                    hist[i] <= card;
                end
            end
        end
    end

    // Read port returns zero for slots not yet dealt this hand.
    always_comb begin
        rd_card = '0;
        for (int i = 0; i < MAX_CARDS; i++) begin
            if ((rd_idx == CNT_W'(i)) && (rd_idx < num_cards)) begin
                rd_card = hist[i];
            end
        end
    end
`endif

endmodule

// File: doc/hand_accumulator.md
# hand_accumulator

Sequential, parametrised hand scorer for the baccarat datapath. Accepts cards one at a time over a valid/ready handshake and keeps a running score modulo `MODULUS`. Also tracks the card count, flags a full hand and flags a two-card natural. Sits between the card dealer and the win/draw decision FSM, one instance per hand (player, banker); this replaces the purely combinational three-card scorer.

## Interface
Parameters:
- `MAX_CARDS`, 3: maximum cards per hand; legal range 2..15.
- `MODULUS`, 10: score modulus; legal range 10..16.
- `SCORE_W`, `$clog2(MODULUS)`: width of `score`; derived, do not override.
- `CNT_W`, `$clog2(MAX_CARDS+1)`: width of `num_cards`; derived.

Ports:
- `slow_clock` in 1: sole clock, rising edge.
- `resetb` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous hand clear (new round).
- `card_valid` in 1: `card` holds a dealt card.
- `card` in 4: card code; 1 = ace, 2..10 = pips, 11..13 = J/Q/K, 0/14/15 illegal.
- `card_ready` out 1: block can accept a card this cycle.
- `score` out `SCORE_W`: running hand score mod `MODULUS`.
- `num_cards` out `CNT_W`: cards accepted since reset/clear.
- `full` out 1: `num_cards == MAX_CARDS`.
- `natural` out 1: exactly two cards held and score is 8 or 9.
- `illegal` out 1: sticky; an illegal code was accepted.

## Operation
- Card value: codes 1..9 give values 1..9; codes 10..13 give 0; illegal codes give 0 and set `illegal`.
- Accept condition is `card_valid && card_ready`. `card_ready = !full && !clear` (combinational).
- On accept:
  - `score <= score + value`, minus `MODULUS` if the sum is ≥ `MODULUS`. One conditional subtract suffices because value ≤ 9 < `MODULUS`.
  - `num_cards <= num_cards + 1`.
- State machine with states EMPTY, COLLECT and DONE.
  - EMPTY → COLLECT on accept.
  - COLLECT → DONE on the accept that makes `num_cards == MAX_CARDS`.
  - Any state → EMPTY on `clear`.
  - `full` is high exactly in DONE.
- `natural` is registered and high only while `num_cards == 2 && score ∈ {8,9}`. It drops when a third card is accepted.
- `clear` has priority over a simultaneous `card_valid`; that card is not accepted (`card_ready` is low). `clear` zeroes `score`, `num_cards` and `illegal`.
- `card_valid` while `full` is ignored with no state change. Upstream must hold the card until `card_ready`.

## Timing
- All outputs are registered except `card_ready`.
- Latency is 1 cycle: a card accepted at edge N is reflected in `score`, `num_cards`, `full`, `natural` and `illegal` after edge N.
- Throughput is one card per cycle.
- Reset values: `score`=0, `num_cards`=0, `full`=0, `natural`=0, `illegal`=0, state EMPTY. `card_ready`=1 once `resetb` is high (given `clear`=0).
- `resetb` asserted mid-hand clears everything immediately, without waiting for a clock edge.

## Configuration
- `HAND_HISTORY_EN` defined:
  - Adds input `rd_idx` [`CNT_W`-1:0] and output `rd_card` [3:0].
  - Every accepted card code is stored at index `num_cards` (pre-increment) in a `MAX_CARDS`-entry register file.
  - `rd_card` is the combinational read of entry `rd_idx`; it returns 0 if `rd_idx >= num_cards`.
  - The file clears on reset and `clear`.
- Undefined: no history storage and no `rd_idx`/`rd_card` ports.

## Structure
- Package `baccarat_pkg` holds:
  - `card_t` (logic [3:0]).
  - Constants `CARD_ACE`=1, `CARD_TEN`=10, `CARD_KING`=13.
  - `NATURAL_LO`=8 and `NATURAL_HI`=9.
  - The state enum `hand_state_e`.
- One sub-module, `card_to_value`: combinational; maps `card_t` to a 4-bit value plus an illegal flag.
- The accumulator, FSM and optional history live in `hand_accumulator`.

## Test plan
- Reset, then cards 7 then 6 → `score`=3, `num_cards`=2, `natural`=0, `full`=0.
- Cards 4 then 5 → `natural`=1 after the second edge. Third card 12 → `score`=9, `natural`=0, `full`=1, `card_ready`=0.
- Full hand (3 cards) plus `card_valid` with card 5 → no change to `score`/`num_cards`. Then `clear`=1 in the same cycle as `card_valid`=1 → next cycle `score`=0, `num_cards`=0, card dropped.
- Card 0 then card 3 → `illegal`=1 (sticky), `score`=3. Then `clear` → `illegal`=0.
- `MAX_CARDS`=5, `MODULUS`=16, cards 9,9,9,9,9 → `score`=13, `full`=1. Assert `resetb` low mid-sequence → all outputs 0 without a clock edge.
- With `HAND_HISTORY_EN` defined, cards 11,2,8 → `rd_idx` 0/1/2 returns 11/2/8 and `rd_idx`=3 returns 0.
